// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - codes and coin/item values shared by the vending front end, core and bench
package vending_pkg;

  typedef enum logic [1:0] {
    SVC_OFF  = 2'b00,
    SVC_ON   = 2'b01,
    SVC_BUSY = 2'b10
  } service_e;

  typedef enum logic [1:0] {
    COIN_50 = 2'b00,
    COIN_10 = 2'b01,
    COIN_5  = 2'b10,
    COIN_1  = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    ITEM_NONE = 2'b00,
    ITEM_A    = 2'b01,
    ITEM_B    = 2'b10,
    ITEM_C    = 2'b11
  } item_e;

  localparam logic [7:0] VAL_50 = 8'd50;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_5  = 8'd5;
  localparam logic [7:0] VAL_1  = 8'd1;

  localparam logic [7:0] COST_A = 8'd8;
  localparam logic [7:0] COST_B = 8'd15;
  localparam logic [7:0] COST_C = 8'd22;

  function automatic logic [7:0] coin_value(input logic [1:0] coin);
    case (coin)
      COIN_50: coin_value = VAL_50;
      COIN_10: coin_value = VAL_10;
      COIN_5:  coin_value = VAL_5;
      default: coin_value = VAL_1;
    endcase
  endfunction

endpackage

// File: rtl/vending_value_calc.sv
// rtl/vending_value_calc.sv - per-denomination coin counts to 8-bit NTD value
module vending_value_calc
  import vending_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] n50_i,
  input  logic [CNT_W-1:0] n10_i,
  input  logic [CNT_W-1:0] n5_i,
  input  logic [CNT_W-1:0] n1_i,
  output logic [7:0]       value_o
);

  // With 2-bit counts the maximum is 198, so 8 bits never wrap.
  assign value_o = (8'(n50_i) * VAL_50) + (8'(n10_i) * VAL_10)
                 + (8'(n5_i) * VAL_5) + (8'(n1_i) * VAL_1);

endmodule

// File: rtl/coin_escrow_front.sv
// rtl/coin_escrow_front.sv - coin escrow and one-shot purchase request front end
// Optional idle auto-refund when ESCROW_TIMEOUT_EN is defined.
module coin_escrow_front
  import vending_pkg::*;
#(
  parameter int CNT_W       = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             coin_valid_i,
  input  logic [1:0]       coin_type_i,
  input  logic             sel_valid_i,
  input  logic [1:0]       sel_item_i,
  input  logic             cancel_i,
  input  logic [1:0]       service_type_i,
  output logic [CNT_W-1:0] req_ntd_50_o,
  output logic [CNT_W-1:0] req_ntd_10_o,
  output logic [CNT_W-1:0] req_ntd_5_o,
  output logic [CNT_W-1:0] req_ntd_1_o,
  output logic [1:0]       req_item_type_o,
  output logic [7:0]       escrow_value_o,
  output logic             coin_reject_o,
  output logic             refund_valid_o,
  output logic             busy_o
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_COLLECT   = 3'd1;
  localparam logic [2:0] ST_ISSUE     = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_REFUND    = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [2:0]            state_q, state_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            req_item_q, req_item_d;
  logic [7:0]            value_q, value_d;
  logic                  reject_q, reject_d;
  logic                  refund_q, refund_d;
  logic                  busy_q, busy_d;
  logic                  coin_fits;
  logic                  sel_real;
  logic                  timeout_hit;

`ifdef ESCROW_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  // Any coin or selection strobe counts as user activity.
  always_comb begin
    idle_cnt_d = '0;
    if (state_q == ST_COLLECT && !coin_valid_i && !sel_valid_i) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == ST_COLLECT) && (idle_cnt_d == IDLE_W'(TIMEOUT_CYC));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_item_d = req_item_q;
    reject_d   = 1'b0;
    coin_fits  = (cnt_q[coin_type_i] != CNT_MAX);
    sel_real   = sel_valid_i && (sel_item_i != ITEM_NONE);

    case (state_q)
      ST_IDLE: begin
        if (coin_valid_i) begin
          if (coin_fits) begin
            cnt_d[coin_type_i] = cnt_q[coin_type_i] + 1'b1;
            state_d            = ST_COLLECT;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      ST_COLLECT: begin
        // Cancel (or timeout) beats both a selection and a coin in the same cycle.
        if (cancel_i || timeout_hit) begin
          reject_d = coin_valid_i;
          state_d  = ST_REFUND;
        end else begin
          if (coin_valid_i) begin
            if (coin_fits) begin
              cnt_d[coin_type_i] = cnt_q[coin_type_i] + 1'b1;
            end else begin
              reject_d = 1'b1;
            end
          end
          if (sel_real) begin
            req_item_d = sel_item_i;
            state_d    = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        reject_d = coin_valid_i;
        if (service_type_i == SVC_ON) begin
          cnt_d      = '0;
          req_item_d = ITEM_NONE;
          state_d    = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        reject_d = coin_valid_i;
        if (service_type_i == SVC_OFF) begin
          state_d = ST_IDLE;
        end
      end
      ST_REFUND: begin
        reject_d = coin_valid_i;
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        cnt_d      = '0;
        req_item_d = ITEM_NONE;
        state_d    = ST_IDLE;
      end
    endcase

    refund_d = (state_d == ST_REFUND);
    busy_d   = (state_d == ST_ISSUE) || (state_d == ST_WAIT_DONE) || (state_d == ST_REFUND);
  end

  vending_value_calc #(
    .CNT_W (CNT_W)
  ) u_value_calc (
    .n50_i   (cnt_d[COIN_50]),
    .n10_i   (cnt_d[COIN_10]),
    .n5_i    (cnt_d[COIN_5]),
    .n1_i    (cnt_d[COIN_1]),
    .value_o (value_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_item_q <= ITEM_NONE;
      value_q    <= '0;
      reject_q   <= 1'b0;
      refund_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_item_q <= req_item_d;
      value_q    <= value_d;
      reject_q   <= reject_d;
      refund_q   <= refund_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ntd_50_o    = cnt_q[COIN_50];
  assign req_ntd_10_o    = cnt_q[COIN_10];
  assign req_ntd_5_o     = cnt_q[COIN_5];
  assign req_ntd_1_o     = cnt_q[COIN_1];
  assign req_item_type_o = req_item_q;
  assign escrow_value_o  = value_q;
  assign coin_reject_o   = reject_q;
  assign refund_valid_o  = refund_q;
  assign busy_o          = busy_q;

endmodule
